// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath and pipeline_hazard_ctrl.
// The master modport is the controller side; the slave modport is the datapath side.
interface pipeline_hazard_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Rs1D;
  logic [ADDR_W-1:0] Rs2D;
  logic [ADDR_W-1:0] Rs1E;
  logic [ADDR_W-1:0] Rs2E;
  logic [ADDR_W-1:0] RdE;
  logic [ADDR_W-1:0] RdM;
  logic [ADDR_W-1:0] RdW;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              LoadE;
  logic              PCSrcE;
  logic              MdReqE;
  logic              MdDone;
  logic              DMemReadyM;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              StallM;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              FlushW;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              MdStart;
  logic              MdResultSelE;

  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MdReqE, MdDone, DMemReadyM,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushM, FlushW,
    output ForwardAE, ForwardBE, MdStart, MdResultSelE
  );

  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MdReqE, MdDone, DMemReadyM,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushM, FlushW,
    input  ForwardAE, ForwardBE, MdStart, MdResultSelE
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller with mul/div sequencing FSM for the 5-stage pipeline.
// Define HAZARD_PERF_EN to add the StallCycles/FlushCount performance counters.
module pipeline_hazard_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic PCSrcE,
  input logic MdReqE
);
  // A mul/div instruction is never a branch, so both cannot be in E together.
  a_no_redirect_md: assert property (@(posedge clk) disable iff (reset) !(PCSrcE && MdReqE))
    else $error("pipeline_hazard_ctrl: PCSrcE and MdReqE high together");
endmodule

module pipeline_hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int PERF_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     StallCycles,
  output logic [PERF_W-1:0]     FlushCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } md_state_e;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  if (ADDR_W < 1 || PERF_W < 1) begin : g_param_check
    $error("pipeline_hazard_ctrl: ADDR_W and PERF_W must be positive");
  end

  md_state_e state_q, state_d;

  logic       mem_stall_s;
  logic       lw_stall_s;
  logic       md_stall_s;
  logic       md_start_s;
  logic       md_sel_s;
  logic       stall_fd_s;
  logic       flush_e_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // Register x0 is never forwarded; the M stage holds the younger result and wins.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] rs,
    input logic              we_m,
    input logic [ADDR_W-1:0] rd_m,
    input logic              we_w,
    input logic [ADDR_W-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != ZERO_REG) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != ZERO_REG) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  always_comb begin
    mem_stall_s = ~hz.DMemReadyM;
    lw_stall_s  = hz.LoadE && (hz.RdE != ZERO_REG) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) && ~hz.PCSrcE;
    md_stall_s  = ((state_q == IDLE) && hz.MdReqE) || ((state_q == BUSY) && ~hz.MdDone);
    fwd_a_s     = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    fwd_b_s     = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    state_d     = state_q;
    md_start_s  = 1'b0;
    md_sel_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.MdReqE && !mem_stall_s) begin
          state_d    = BUSY;
          md_start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // The result must be held in HOLD if M is waiting when the unit finishes.
        if (hz.MdDone) begin
          md_sel_s = 1'b1;
          state_d  = mem_stall_s ? HOLD : IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      HOLD: begin
        md_sel_s = 1'b1;
        state_d  = mem_stall_s ? HOLD : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    stall_fd_s      = 1'b0;
    flush_e_s       = 1'b0;
    hz.StallF       = 1'b0;
    hz.StallD       = 1'b0;
    hz.StallE       = 1'b0;
    hz.StallM       = 1'b0;
    hz.FlushD       = 1'b0;
    hz.FlushE       = 1'b0;
    hz.FlushM       = 1'b0;
    hz.FlushW       = 1'b0;
    hz.ForwardAE    = 2'b00;
    hz.ForwardBE    = 2'b00;
    hz.MdStart      = 1'b0;
    hz.MdResultSelE = 1'b0;
    if (reset) begin
      stall_fd_s = 1'b0;
      flush_e_s  = 1'b0;
    end else begin
      // A memory wait freezes F..M and defers redirect/bubbles until M can retire.
      stall_fd_s      = mem_stall_s | lw_stall_s | md_stall_s;
      flush_e_s       = (lw_stall_s | hz.PCSrcE) & ~mem_stall_s;
      hz.StallF       = stall_fd_s;
      hz.StallD       = stall_fd_s;
      hz.StallE       = mem_stall_s | md_stall_s;
      hz.StallM       = mem_stall_s;
      hz.FlushD       = hz.PCSrcE & ~mem_stall_s;
      hz.FlushE       = flush_e_s;
      hz.FlushM       = md_stall_s & ~mem_stall_s;
      hz.FlushW       = mem_stall_s;
      hz.ForwardAE    = fwd_a_s;
      hz.ForwardBE    = fwd_b_s;
      hz.MdStart      = md_start_s;
      hz.MdResultSelE = md_sel_s;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_count_q,  flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_fd_s) begin
      stall_cycles_d = stall_cycles_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (flush_e_s) begin
      flush_count_d = flush_count_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`endif

  pipeline_hazard_ctrl_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .PCSrcE (hz.PCSrcE),
    .MdReqE (hz.MdReqE)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl; exercises perf counters when HAZARD_PERF_EN is defined.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    string       tag;
    logic [13:0] vec;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];

  pipeline_hazard_ctrl_if #(.ADDR_W(5)) hz_if ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipeline_hazard_ctrl #(.ADDR_W(5), .PERF_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
`ifdef HAZARD_PERF_EN
    ,
    .StallCycles (stall_cycles),
    .FlushCount  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.StallM,
                hz_if.FlushD, hz_if.FlushE, hz_if.FlushM, hz_if.FlushW,
                hz_if.ForwardAE, hz_if.ForwardBE, hz_if.MdStart, hz_if.MdResultSelE};

  // Expected output vector in the same field order as obs.
  function automatic logic [13:0] ev(
    input logic sf, input logic sd, input logic se, input logic sm,
    input logic fd, input logic fe, input logic fm, input logic fw,
    input logic [1:0] fa, input logic [1:0] fb, input logic ms, input logic mr
  );
    return {sf, sd, se, sm, fd, fe, fm, fw, fa, fb, ms, mr};
  endfunction

  task automatic clear_inputs();
    hz_if.Rs1D = 5'd0; hz_if.Rs2D = 5'd0; hz_if.Rs1E = 5'd0; hz_if.Rs2E = 5'd0;
    hz_if.RdE = 5'd0; hz_if.RdM = 5'd0; hz_if.RdW = 5'd0;
    hz_if.RegWriteM = 1'b0; hz_if.RegWriteW = 1'b0; hz_if.LoadE = 1'b0;
    hz_if.PCSrcE = 1'b0; hz_if.MdReqE = 1'b0; hz_if.MdDone = 1'b0;
    hz_if.DMemReadyM = 1'b1;
  endtask

  task automatic check(input string tag, input logic [13:0] exp_vec);
    exp_t e;
    sb.push_back('{tag, exp_vec});
    #2;
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.vec) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic check_cnt(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, x);
    end
  endtask
`endif

  localparam logic [13:0] Z = 14'd0;

  initial begin
    logic [13:0] v_start;
    logic [13:0] v_busy;
    logic [13:0] v_done;
    logic [13:0] v_mem;
    logic [13:0] v_mem_sel;
    n_cmp  = 0;
    n_fail = 0;
    v_start   = ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    v_busy    = ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    v_done    = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    v_mem     = ev(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    v_mem_sel = ev(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1);

    // Reset with busy inputs: every output must be forced low.
    reset = 1'b1;
    clear_inputs();
    hz_if.MdReqE = 1'b1; hz_if.DMemReadyM = 1'b0; hz_if.LoadE = 1'b1;
    hz_if.RdE = 5'd7; hz_if.Rs1D = 5'd7;
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd5; hz_if.Rs1E = 5'd5;
    @(negedge clk); check("reset_outputs", Z);
    @(negedge clk); check("reset_hold", Z);
    @(negedge clk); reset = 1'b0; clear_inputs(); check("post_reset", Z);

    // Forwarding priority and x0 handling.
    @(negedge clk); clear_inputs();
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd5; hz_if.RegWriteW = 1'b1; hz_if.RdW = 5'd5; hz_if.Rs1E = 5'd5;
    check("fwd_a_m", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0));
    @(negedge clk); hz_if.RdM = 5'd0;
    check("fwd_a_w", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0));
    @(negedge clk); hz_if.RdW = 5'd0; hz_if.Rs2E = 5'd0;
    check("fwd_x0", Z);
    @(negedge clk); clear_inputs();
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd3; hz_if.RegWriteW = 1'b1; hz_if.RdW = 5'd3;
    hz_if.Rs2E = 5'd3; hz_if.Rs1E = 5'd9;
    check("fwd_b_m", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0));
    @(negedge clk); hz_if.RegWriteM = 1'b0;
    check("fwd_b_w", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0));

    // Load-use stall, overridden by a redirect, and ignored for x0.
    @(negedge clk); clear_inputs();
    hz_if.LoadE = 1'b1; hz_if.RdE = 5'd7; hz_if.Rs2D = 5'd7;
    check("lw_use", ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
    @(negedge clk); hz_if.PCSrcE = 1'b1;
    check("lw_redirect", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
    @(negedge clk); clear_inputs(); hz_if.LoadE = 1'b1; hz_if.RdE = 5'd0; hz_if.Rs1D = 5'd0;
    check("lw_rd_x0", Z);

    // Plain mul/div: start, three busy cycles, done.
    @(negedge clk); clear_inputs(); hz_if.MdReqE = 1'b1; check("md_start", v_start);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("md_busy", v_busy);
    end
    @(negedge clk); hz_if.MdDone = 1'b1; check("md_done", v_done);
    @(negedge clk); clear_inputs(); check("md_back_idle", Z);

    // Request during a memory wait must not start; done during a wait enters HOLD.
    @(negedge clk); hz_if.MdReqE = 1'b1; hz_if.DMemReadyM = 1'b0; check("md_req_memwait", v_mem);
    @(negedge clk); hz_if.DMemReadyM = 1'b1; check("md_start_late", v_start);
    @(negedge clk); check("md_busy2", v_busy);
    @(negedge clk); hz_if.MdDone = 1'b1; hz_if.DMemReadyM = 1'b0; check("md_done_memwait", v_mem_sel);
    @(negedge clk); hz_if.MdDone = 1'b0; check("md_hold1", v_mem_sel);
    @(negedge clk); check("md_hold2", v_mem_sel);
    @(negedge clk); hz_if.DMemReadyM = 1'b1; check("md_hold_release", v_done);
    @(negedge clk); clear_inputs(); check("md_hold_idle", Z);

    // Reset while BUSY returns the FSM to IDLE.
    @(negedge clk); hz_if.MdReqE = 1'b1; check("md_start3", v_start);
    @(negedge clk); check("md_busy3", v_busy);
    @(negedge clk); reset = 1'b1; check("reset_in_busy", Z);
    @(negedge clk); reset = 1'b0; check("restart_after_reset", v_start);
    @(negedge clk); hz_if.MdDone = 1'b1; check("md_done3", v_done);
    @(negedge clk); clear_inputs(); check("md_idle3", Z);

    // Memory wait defers a redirect.
    @(negedge clk); hz_if.DMemReadyM = 1'b0; hz_if.PCSrcE = 1'b1; check("redirect_memwait", v_mem);
    @(negedge clk); hz_if.DMemReadyM = 1'b1;
    check("redirect_release", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));

`ifdef HAZARD_PERF_EN
    @(negedge clk); clear_inputs(); reset = 1'b1; check("perf_reset", Z);
    @(negedge clk); check_cnt("stall_cycles_reset", stall_cycles, 32'd0);
    check_cnt("flush_count_reset", flush_count, 32'd0);
    @(negedge clk); reset = 1'b0; check("perf_idle", Z);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); hz_if.LoadE = 1'b1; hz_if.RdE = 5'd7; hz_if.Rs1D = 5'd7;
      check("perf_lw", ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
    end
    @(negedge clk); clear_inputs(); check("perf_after", Z);
    check_cnt("stall_cycles", stall_cycles, 32'd3);
    check_cnt("flush_count", flush_count, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
